fir_nibble_collector: RTL and testbench

//  Downstream sink of the 8-PE nibble-serial filter array. Collects the LSB-first
//  4-bit X/Y nibble stream qualified by the last stage's Vld and reassembles full words.

---
 rtl/fir_nibble_collector_pkg.sv | 30 +++
 rtl/fir_nibble_collector_if.sv | 39 +++
 rtl/fir_nibble_collector_sync_fifo.sv | 64 ++++++
 rtl/fir_nibble_collector.sv | 143 ++++++++++++++
 tb/tb_fir_nibble_collector.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/fir_nibble_collector_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fir_array_pkg
//  Description : Constants and types shared by the nibble-serial filter array
//                and its downstream collector. This includes the nibble width,
//                the array length, the coefficient table and the word-assembly
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_array_pkg;

   localparam int NIBBLE_W   = 4;
   localparam int N_PE_ARRAY = 8;

   // Symmetric low-pass taps used by the array (6-bit unsigned)
   localparam logic [5:0] COEFF_TABLE [N_PE_ARRAY] =
      '{6'd4, 6'd12, 6'd25, 6'd34, 6'd34, 6'd25, 6'd12, 6'd4};

   typedef enum logic [0:0] {
      ASM_IDLE    = 1'b0,
      ASM_COLLECT = 1'b1
   } asm_state_e;

   // Bit position of nibble 'idx' inside an assembled word
   function automatic int nibble_lsb(input int idx);
      return idx * NIBBLE_W;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fir_nibble_collector_if.sv
`default_nettype none
// ============================================================================
//  Interface   : fir_nibble_collector_if
//  Description : Nibble stream from the array's last stage plus the
//                valid/ready word-pair output toward the system side.
//  Signals     : Vld        nibble strobe
//                Xout/Yout  X / Y nibble, LSB nibble first
//                out_valid  head word pair available
//                out_ready  consumer accepts head word pair
//                out_x/y    reassembled X / Y word at FIFO head
//  Modports    : master - array + consumer side, slave - collector
//  Revision    : 1.0 - initial release
// ============================================================================
interface fir_nibble_collector_if
   import fir_array_pkg::*;
#(
   parameter int W = 16
) ();

   logic                Vld;
   logic [NIBBLE_W-1:0] Xout;
   logic [NIBBLE_W-1:0] Yout;
   logic                out_valid;
   logic                out_ready;
   logic [W-1:0]        out_x;
   logic [W-1:0]        out_y;

   modport master (
      output Vld, Xout, Yout, out_ready,
      input  out_valid, out_x, out_y
   );

   modport slave (
      input  Vld, Xout, Yout, out_ready,
      output out_valid, out_x, out_y
   );

endinterface
`default_nettype wire

// File: rtl/fir_nibble_collector_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with a valid/ready read side. Pointers
//                carry one extra wrap bit so that full and empty can be told
//                apart. A write into a full FIFO is accepted only when the
//                head is popped in the same cycle.
//  Ports       : clk, reset         clock, synchronous active-high reset
//                wr_en, wr_data     write request / data
//                full, empty, fill  occupancy status
//                rd_valid, rd_ready, rd_data  head entry handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     full,
   output logic                     empty,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   fill
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push;
   logic             w_pop;

   assign empty    = (r_wr_ptr == r_rd_ptr);
   assign full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign fill     = r_wr_ptr - r_rd_ptr;
   assign rd_valid = ~empty;
   assign rd_data  = r_mem[r_rd_ptr[AW-1:0]];

   assign w_pop  = rd_valid & rd_ready;
   // When full, the slot being written is the one vacated by the pop
   assign w_push = wr_en & (~full | w_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule
`default_nettype wire

// File: rtl/fir_nibble_collector.sv
`default_nettype none
// ============================================================================
//  Module      : fir_nibble_collector
//  Description : Sink of the nibble-serial filter array. It reassembles
//                LSB-first X/Y nibbles into full words and buffers completed
//                pairs in a FIFO. It drops partial words when the stream stalls
//                and flags overflow and framing errors with sticky bits.
//  Ports       : clk        clock
//                reset      synchronous active-high reset
//                bus        nibble stream in / word pair out (slave modport)
//                overflow   sticky, a completed word was lost to a full FIFO
//                frame_err  sticky, a partial word timed out
//                fill       FIFO occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_nibble_collector
   import fir_array_pkg::*;
#(
   parameter int NIBBLES    = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_MAX    = 15
) (
   input  logic                         clk,
   input  logic                         reset,
   fir_nibble_collector_if.slave        bus,
   output logic                         overflow,
   output logic                         frame_err,
   output logic [$clog2(FIFO_DEPTH):0]  fill
);

   localparam int W  = NIBBLE_W * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam int GW = $clog2(GAP_MAX + 1);

   localparam logic [0:0] S_IDLE    = ASM_IDLE;
   localparam logic [0:0] S_COLLECT = ASM_COLLECT;

   logic [0:0]     r_state;
   logic [IW-1:0]  r_idx;
   logic [GW-1:0]  r_gap;
   logic [W-1:0]   r_x_sh;
   logic [W-1:0]   r_y_sh;
   logic           r_overflow;
   logic           r_frame_err;

   logic [IW-1:0]  w_idx;
   logic [W-1:0]   w_x_asm;
   logic [W-1:0]   w_y_asm;
   logic           w_last;
   logic           w_full;
   logic           w_empty;
   logic           w_rd_valid;
   logic [2*W-1:0] w_rd_data;

   // Word as it looks with the current nibble merged in. A new word starts
   // from zero so no stale bits of a discarded partial word leak through.
   always_comb begin
      w_idx   = (r_state == S_IDLE) ? '0 : r_idx;
      w_x_asm = (r_state == S_IDLE) ? '0 : r_x_sh;
      w_y_asm = (r_state == S_IDLE) ? '0 : r_y_sh;
      w_x_asm[nibble_lsb(int'(w_idx)) +: NIBBLE_W] = bus.Xout;
      w_y_asm[nibble_lsb(int'(w_idx)) +: NIBBLE_W] = bus.Yout;
      w_last  = bus.Vld && (w_idx == IW'(NIBBLES - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_gap       <= '0;
         r_x_sh      <= '0;
         r_y_sh      <= '0;
         r_overflow  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.Vld) begin
                  r_x_sh <= w_x_asm;
                  r_y_sh <= w_y_asm;
                  r_gap  <= '0;
                  // Single-nibble words complete here and never leave IDLE
                  if (!w_last) begin
                     r_state <= S_COLLECT;
                     r_idx   <= IW'(1);
                  end
               end
            end
            S_COLLECT: begin
               if (bus.Vld) begin
                  r_x_sh <= w_x_asm;
                  r_y_sh <= w_y_asm;
                  r_gap  <= '0;
                  if (w_last) begin
                     r_state <= S_IDLE;
                     r_idx   <= '0;
                  end else begin
                     r_idx <= r_idx + IW'(1);
                  end
               end else if (r_gap == GW'(GAP_MAX - 1)) begin
                  r_state     <= S_IDLE;
                  r_idx       <= '0;
                  r_gap       <= '0;
                  r_frame_err <= 1'b1;
               end else begin
                  r_gap <= r_gap + GW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // The array cannot be stalled, so a full FIFO without a
         // simultaneous pop means the word is gone
         if (w_last && w_full && !(w_rd_valid && bus.out_ready))
            r_overflow <= 1'b1;
      end
   end

   sync_fifo #(
      .WIDTH (2 * W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (w_last),
      .wr_data  ({w_x_asm, w_y_asm}),
      .full     (w_full),
      .empty    (w_empty),
      .rd_valid (w_rd_valid),
      .rd_ready (bus.out_ready),
      .rd_data  (w_rd_data),
      .fill     (fill)
   );

   // Storage is not cleared on reset, so data is masked while empty
   assign bus.out_valid = w_rd_valid;
   assign bus.out_x     = w_empty ? '0 : w_rd_data[2*W-1:W];
   assign bus.out_y     = w_empty ? '0 : w_rd_data[W-1:0];
   assign overflow      = r_overflow;
   assign frame_err     = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_fir_nibble_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_nibble_collector
//  Description : Self-checking bench for fir_nibble_collector, using directed
//                word vectors plus hand-written multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_nibble_collector;

   logic       clk = 1'b0;
   logic       reset;
   logic       overflow;
   logic       frame_err;
   logic [2:0] fill;

   int checks = 0;
   int errors = 0;

   fir_nibble_collector_if #(.W(16)) bus ();

   fir_nibble_collector #(
      .NIBBLES    (4),
      .FIFO_DEPTH (4),
      .GAP_MAX    (15)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .overflow  (overflow),
      .frame_err (frame_err),
      .fill      (fill)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_before;
      logic [15:0] x;
      logic [15:0] y;
      logic        rdy;
      logic        rdy_last;
      logic        exp_valid;
      logic [15:0] exp_x;
      logic [15:0] exp_y;
      logic [2:0]  exp_fill;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs [10];

   function automatic logic [15:0] rep(input int k);
      logic [3:0] n;
      n = 4'(k);
      return {n, n, n, n};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] x, input logic [3:0] y, input logic rdy);
      bus.Vld       = v;
      bus.Xout      = x;
      bus.Yout      = y;
      bus.out_ready = rdy;
      step();
   endtask

   task automatic idle(input logic rdy, input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 4'h0, rdy);
   endtask

   task automatic send_word(input logic [15:0] x, input logic [15:0] y,
                            input logic rdy, input logic rdy_last);
      for (int i = 0; i < 4; i++)
         drive(1'b1, x[4*i +: 4], y[4*i +: 4], (i == 3) ? rdy_last : rdy);
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      bus.Vld       = 1'b0;
      bus.out_ready = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic check_out(input string tag, input logic v, input logic [15:0] x,
                            input logic [15:0] y, input logic [2:0] f);
      check({tag, " out_valid"}, 32'(bus.out_valid), 32'(v));
      check({tag, " out_x"},     32'(bus.out_x),     32'(x));
      check({tag, " out_y"},     32'(bus.out_y),     32'(y));
      check({tag, " fill"},      32'(fill),          32'(f));
   endtask

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         if (vecs[i].rst_before) do_reset();
         send_word(vecs[i].x, vecs[i].y, vecs[i].rdy, vecs[i].rdy_last);
         check_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_x,
                   vecs[i].exp_y, vecs[i].exp_fill);
         check($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
         check($sformatf("vec%0d frame_err", i), 32'(frame_err), 32'd0);
      end
   endtask

   // Pops four words of the form {kkkk, (15-k)(15-k)..} starting at k = first
   task automatic drain(input string tag, input int first);
      for (int k = first; k < first + 4; k++) begin
         check_out($sformatf("%s head%0d", tag, k), 1'b1, rep(k), rep(15 - k),
                   3'(4 - (k - first)));
         drive(1'b0, 4'h0, 4'h0, 1'b1);
      end
      check_out({tag, " empty"}, 1'b0, 16'h0, 16'h0, 3'd0);
   endtask

   initial begin
      vecs[0] = '{1'b1, rep(1), rep(14), 1'b0, 1'b0, 1'b1, rep(1), rep(14), 3'd1, 1'b0};
      vecs[1] = '{1'b0, rep(2), rep(13), 1'b0, 1'b0, 1'b1, rep(1), rep(14), 3'd2, 1'b0};
      vecs[2] = '{1'b0, rep(3), rep(12), 1'b0, 1'b0, 1'b1, rep(1), rep(14), 3'd3, 1'b0};
      vecs[3] = '{1'b0, rep(4), rep(11), 1'b0, 1'b0, 1'b1, rep(1), rep(14), 3'd4, 1'b0};
      vecs[4] = '{1'b0, rep(5), rep(10), 1'b0, 1'b0, 1'b1, rep(1), rep(14), 3'd4, 1'b1};
      vecs[5] = '{1'b1, rep(1), rep(14), 1'b0, 1'b0, 1'b1, rep(1), rep(14), 3'd1, 1'b0};
      vecs[6] = '{1'b0, rep(2), rep(13), 1'b0, 1'b0, 1'b1, rep(1), rep(14), 3'd2, 1'b0};
      vecs[7] = '{1'b0, rep(3), rep(12), 1'b0, 1'b0, 1'b1, rep(1), rep(14), 3'd3, 1'b0};
      vecs[8] = '{1'b0, rep(4), rep(11), 1'b0, 1'b0, 1'b1, rep(1), rep(14), 3'd4, 1'b0};
      // Final nibble lands while full and the head is popped
      vecs[9] = '{1'b0, rep(5), rep(10), 1'b0, 1'b1, 1'b1, rep(2), rep(13), 3'd4, 1'b0};

      reset         = 1'b1;
      bus.Vld       = 1'b0;
      bus.Xout      = 4'h0;
      bus.Yout      = 4'h0;
      bus.out_ready = 1'b0;

      // Reset state, then four back-to-back nibbles
      do_reset();
      check_out("reset", 1'b0, 16'h0, 16'h0, 3'd0);
      check("reset overflow",  32'(overflow),  32'd0);
      check("reset frame_err", 32'(frame_err), 32'd0);
      drive(1'b1, 4'h1, 4'hA, 1'b1);
      drive(1'b1, 4'h2, 4'hB, 1'b1);
      drive(1'b1, 4'h3, 4'hC, 1'b1);
      check("t1 before last out_valid", 32'(bus.out_valid), 32'd0);
      drive(1'b1, 4'h4, 4'hD, 1'b1);
      check_out("t1 word", 1'b1, 16'h4321, 16'hDCBA, 3'd1);
      drive(1'b0, 4'h0, 4'h0, 1'b1);
      check_out("t1 popped", 1'b0, 16'h0, 16'h0, 3'd0);

      // Three idle cycles between strobes
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 4'(i + 1), 4'(10 + i), 1'b1);
         if (i < 3) idle(1'b1, 3);
      end
      check_out("t2 word", 1'b1, 16'h4321, 16'hDCBA, 3'd1);
      check("t2 frame_err", 32'(frame_err), 32'd0);
      idle(1'b1, 1);
      check("t2 popped out_valid", 32'(bus.out_valid), 32'd0);

      // Gap of GAP_MAX-1 idle cycles is still tolerated
      drive(1'b1, 4'h9, 4'h9, 1'b1);
      drive(1'b1, 4'h9, 4'h9, 1'b1);
      idle(1'b1, 14);
      check("t14 frame_err", 32'(frame_err), 32'd0);
      drive(1'b1, 4'h9, 4'h9, 1'b1);
      drive(1'b1, 4'h9, 4'h9, 1'b1);
      check_out("t14 word", 1'b1, 16'h9999, 16'h9999, 3'd1);
      idle(1'b1, 1);

      // Gap of GAP_MAX idle cycles discards the partial word
      drive(1'b1, 4'h1, 4'h2, 1'b0);
      drive(1'b1, 4'h1, 4'h2, 1'b0);
      idle(1'b0, 14);
      check("t3 frame_err at 14", 32'(frame_err), 32'd0);
      idle(1'b0, 1);
      check("t3 frame_err at 15", 32'(frame_err), 32'd1);
      check("t3 fill after drop", 32'(fill), 32'd0);
      send_word(16'h8765, 16'h4321, 1'b0, 1'b0);
      check_out("t3 word", 1'b1, 16'h8765, 16'h4321, 3'd1);

      // Reset mid-word with FIFO occupied and frame_err set
      drive(1'b1, 4'hF, 4'hF, 1'b0);
      drive(1'b1, 4'hF, 4'hF, 1'b0);
      do_reset();
      check_out("t6 reset", 1'b0, 16'h0, 16'h0, 3'd0);
      check("t6 overflow",  32'(overflow),  32'd0);
      check("t6 frame_err", 32'(frame_err), 32'd0);
      send_word(16'hDCBA, 16'h4321, 1'b0, 1'b0);
      check_out("t6 clean word", 1'b1, 16'hDCBA, 16'h4321, 3'd1);

      // Overflow: five words into a four-deep FIFO with no consumer
      run_vecs(0, 4);
      drain("t4", 1);
      check("t4 overflow sticky", 32'(overflow), 32'd1);

      // Push and pop together while full
      run_vecs(5, 9);
      drain("t5", 2);
      check("t5 overflow", 32'(overflow), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
